alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised successor to the CPU's combinational 8-bit add/sub ALU.
- Operations: add, sub, bitwise logic, single-bit shifts, and a multi-cycle shift-add multiply.
- Results and a four-flag status set (carry, zero, negative, overflow) are held in registers.
- Sits between the A/B registers and the bus. The control sequencer issues operations with a start/busy/done handshake.

Parameters:
- WIDTH, 8, datapath width in bits (≥2). Sets operand, result and iteration-count width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable. 0: start ignored, in-flight multiply paused, outputs held.
- start  in  1  request an operation. Sampled on rising clk when en=1 and busy=0.
- op  in  3  operation code, captured with start.
- reg_a_in  in  WIDTH  operand A, captured with start.
- reg_b_in  in  WIDTH  operand B, captured with start.
- res_out  out  WIDTH  registered result.
- carry_out  out  1  registered carry/borrow flag.
- zero_out  out  1  registered flag: res_out == 0.
- neg_out  out  1  registered flag: res_out[WIDTH-1].
- ovf_out  out  1  registered signed-overflow flag.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse: new result/flags now valid.

Behaviour:
- Reset (rst=1 at rising clk): res_out=0, all flags=0, busy=0, done=0, state=IDLE. Aborts any in-flight multiply; no done is produced for it.
- Op codes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1. carry_out=1 means no borrow (A≥B unsigned).
  - 010 AND, 011 OR, 100 XOR.
  - 101 SHL: A<<1, carry=A[WIDTH-1].
  - 110 SHR: logical A>>1, carry=A[0].
  - 111 MUL: unsigned A*B. res_out = low WIDTH bits; carry_out = OR of high WIDTH bits.
- Flags:
  - ovf_out is signed overflow for ADD/SUB only; 0 for all other ops.
  - Logic ops force carry_out=0.
  - zero_out and neg_out are computed from the result actually written.
- State machine: IDLE, MUL.
  - IDLE with start & en, non-MUL op: result and flags written at that same edge; done=1 for the following cycle; stays IDLE. Latency 1 cycle.
  - IDLE with start & en, op=MUL: operands latched, counter cleared, accumulator cleared, busy=1 from next cycle, go to MUL.
  - MUL: one shift-add iteration per clk with en=1. With en=0 the counter and accumulator hold.
  - After WIDTH active iterations: result and flags written, busy=0, done=1 for one cycle, return to IDLE.
  - MUL latency with en held high: start edge + WIDTH edges.
- Handshake rules:
  - start while busy=1 is ignored, including op and operands.
  - start held high across the done cycle launches a new operation at the next edge (back-to-back allowed; done may be high on consecutive cycles).
- Hold rules:
  - Between operations, res_out and flags hold their last values.
  - Operand inputs changing during MUL have no effect.
- Width rule: all arithmetic is modulo 2^WIDTH. A WIDTH+1-bit internal sum provides carry.
- Simultaneous events: rst has priority over start and en. en=0 in the same cycle as start means no operation is launched.

Test Plan:
- ADD wrap: WIDTH=8, A=FF, B=01, op=000, start pulse -> next cycle res=00, carry=1, zero=1, neg=0, ovf=0, done=1 for exactly 1 cycle.
- SUB/overflow: A=80, B=01, op=001 -> res=7F, carry=1, ovf=1, neg=0. Then A=01, B=02 -> res=FF, carry=0, neg=1, ovf=0.
- Shifts/logic: A=81, op=101 -> res=02, carry=1. op=110 -> res=40, carry=1. A=F0, B=3C, op=100 -> res=CC, carry=0.
- MUL timing:
  - A=10, B=11, op=111 -> busy high exactly 8 cycles; res=10 (low byte of 0x110), carry=1, done on cycle 9.
  - A=0F, B=0F -> res=E1, carry=0.
  - A start issued mid-multiply is ignored.
- Enable/reset mid-op: start MUL, drop en for 3 cycles mid-run -> done delayed exactly 3 cycles, same result. Restart MUL and assert rst at iteration 4 -> all outputs 0, no done, next ADD works normally.
- Parametrisation: rerun ADD wrap and MUL checks at WIDTH=16 (A=FFFF, B=0001 -> res=0000, carry=1). MUL busy for 16 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered add/sub/logic/shift ALU with a multi-cycle shift-add multiply and start/busy/done handshake
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] reg_a_in,
  input  logic [WIDTH-1:0] reg_b_in,
  output logic [WIDTH-1:0] res_out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             neg_out,
  output logic             ovf_out,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_n, mcand;
  logic [WIDTH-1:0] mplier, bx, r;
  logic [WIDTH:0] sum;
  logic c, v, wr, launch;
  assign launch = en && start && state == IDLE;
  // SUB reuses the adder as A + ~B + 1; op[0] selects the inversion and the carry-in
  assign bx = op[0] ? ~reg_b_in : reg_b_in;
  assign sum = {1'b0, reg_a_in} + {1'b0, bx} + {{WIDTH{1'b0}}, op[0]};
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  assign busy = state == MUL;
  always_comb begin
    state_n = state;
    wr = 1'b0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    if (launch && op == 3'b111) state_n = MUL;
    else if (launch) begin
      wr = 1'b1;
      case (op)
        3'b000, 3'b001: begin
          r = sum[WIDTH-1:0];
          c = sum[WIDTH];
          v = (reg_a_in[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != reg_a_in[WIDTH-1]);
        end
        3'b010: r = reg_a_in & reg_b_in;
        3'b011: r = reg_a_in | reg_b_in;
        3'b100: r = reg_a_in ^ reg_b_in;
        3'b101: begin
          r = reg_a_in << 1;
          c = reg_a_in[WIDTH-1];
        end
        default: begin
          r = reg_a_in >> 1;
          c = reg_a_in[0];
        end
      endcase
    end else if (en && state == MUL && cnt == CW'(WIDTH - 1)) begin
      state_n = IDLE;
      wr = 1'b1;
      r = acc_n[WIDTH-1:0];
      c = |acc_n[2*WIDTH-1:WIDTH];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      res_out <= '0;
      carry_out <= 1'b0;
      zero_out <= 1'b0;
      neg_out <= 1'b0;
      ovf_out <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else begin
      done <= wr;
      if (wr) begin
        res_out <= r;
        carry_out <= c;
        zero_out <= r == '0;
        neg_out <= r[WIDTH-1];
        ovf_out <= v;
      end
      if (launch && op == 3'b111) begin
        mcand <= {{WIDTH{1'b0}}, reg_a_in};
        mplier <= reg_b_in;
        acc <= '0;
        cnt <= '0;
      end else if (en && state == MUL) begin
        acc <= acc_n;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: runs 8- and 16-bit alu_seq side by side against an arithmetic reference model
module tb_alu_seq;
  logic clk = 0, rst, en, start;
  logic [2:0] op_i;
  logic [15:0] a_i, b_i;
  logic [7:0] res8;
  logic [15:0] res16;
  logic c8, z8, n8, v8, busy8, done8, c16, z16, n16, v16, busy16, done16;
  logic [19:0] o8, o16;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .start(start), .op(op_i),
    .reg_a_in(a_i[7:0]), .reg_b_in(b_i[7:0]), .res_out(res8),
    .carry_out(c8), .zero_out(z8), .neg_out(n8), .ovf_out(v8),
    .busy(busy8), .done(done8)
  );
  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .start(start), .op(op_i),
    .reg_a_in(a_i), .reg_b_in(b_i), .res_out(res16),
    .carry_out(c16), .zero_out(z16), .neg_out(n16), .ovf_out(v16),
    .busy(busy16), .done(done16)
  );
  assign o8 = {c8, z8, n8, v8, 8'h00, res8};
  assign o16 = {c16, z16, n16, v16, res16};
  // packs {carry, zero, neg, ovf, result} for a w-bit ALU
  function automatic logic [19:0] model(int w, logic [2:0] op, logic [15:0] a_in, logic [15:0] b_in);
    longint unsigned m, a, b, r, p;
    bit c, v, sa, sb, sr;
    m = (64'd1 << w) - 1;
    a = a_in & m;
    b = b_in & m;
    c = 0;
    v = 0;
    case (op)
      3'd0: begin p = a + b; r = p & m; c = p > m; end
      3'd1: begin r = (a - b) & m; c = a >= b; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = (a << 1) & m; c = ((a >> (w - 1)) & 1) != 0; end
      3'd6: begin r = a >> 1; c = (a & 1) != 0; end
      default: begin p = a * b; r = p & m; c = (p >> w) != 0; end
    endcase
    sa = ((a >> (w - 1)) & 1) != 0;
    sb = ((b >> (w - 1)) & 1) != 0;
    sr = ((r >> (w - 1)) & 1) != 0;
    if (op == 3'd0) v = (sa == sb) && (sr != sa);
    if (op == 3'd1) v = (sa != sb) && (sr != sa);
    return {c, r == 0, sr, v, 16'(r)};
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // issue one op; optionally a start attempt while busy and a 3-cycle en drop
  task automatic run(logic [2:0] op, logic [15:0] a, logic [15:0] b, bit poke, bit stall);
    logic [19:0] e8, e16, g8, g16;
    int l8, l16, bc8, bc16, d8, d16, x;
    bit mul;
    e8 = model(8, op, a, b);
    e16 = model(16, op, a, b);
    mul = op == 3'd7;
    x = (mul && stall) ? 3 : 0;
    l8 = 0; l16 = 0; bc8 = 0; bc16 = 0; d8 = 0; d16 = 0; g8 = '0; g16 = '0;
    @(negedge clk);
    start = 1; op_i = op; a_i = a; b_i = b;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (done8) begin d8++; if (l8 == 0) begin l8 = c; g8 = o8; end end
      if (done16) begin d16++; if (l16 == 0) begin l16 = c; g16 = o16; end end
      bc8 += int'(busy8);
      bc16 += int'(busy16);
      start = poke && mul && c == 2;
      op_i = 3'($urandom);
      a_i = 16'($urandom);
      b_i = 16'($urandom);
      en = !(stall && c >= 3 && c <= 5);
    end
    chk("lat8", l8, mul ? 9 + x : 1);
    chk("lat16", l16, mul ? 17 + x : 1);
    chk("busy8", bc8, mul ? 8 + x : 0);
    chk("busy16", bc16, mul ? 16 + x : 0);
    chk("done8", d8, 1);
    chk("done16", d16, 1);
    chk("out8", g8, e8);
    chk("out16", g16, e16);
    chk("hold8", o8, e8);
    chk("hold16", o16, e16);
  endtask
  initial begin
    int d;
    rst = 1; en = 1; start = 0; op_i = 0; a_i = 0; b_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst8", {busy8, done8, o8}, 0);
    chk("rst16", {busy16, done16, o16}, 0);
    run(3'd0, 16'hFFFF, 16'h0001, 0, 0);
    run(3'd1, 16'h0080, 16'h0001, 0, 0);
    run(3'd1, 16'h8000, 16'h0001, 0, 0);
    run(3'd1, 16'h0001, 16'h0002, 0, 0);
    run(3'd5, 16'h8081, 16'h0000, 0, 0);
    run(3'd6, 16'h0081, 16'h0000, 0, 0);
    run(3'd4, 16'h00F0, 16'h003C, 0, 0);
    run(3'd7, 16'h0010, 16'h0011, 0, 0);
    run(3'd7, 16'h000F, 16'h000F, 1, 0);
    run(3'd7, 16'hFFFF, 16'hFFFF, 0, 1);
    @(negedge clk);
    start = 1; op_i = 3'd0; a_i = 16'h0001; b_i = 16'h0002;
    @(negedge clk);
    chk("b2b_a8", {done8, o8}, {1'b1, model(8, 3'd0, 16'h0001, 16'h0002)});
    chk("b2b_a16", {done16, o16}, {1'b1, model(16, 3'd0, 16'h0001, 16'h0002)});
    op_i = 3'd1; a_i = 16'h0003; b_i = 16'h0004;
    @(negedge clk);
    chk("b2b_b8", {done8, o8}, {1'b1, model(8, 3'd1, 16'h0003, 16'h0004)});
    chk("b2b_b16", {done16, o16}, {1'b1, model(16, 3'd1, 16'h0003, 16'h0004)});
    start = 0;
    @(negedge clk);
    chk("b2b_end", {done8, done16}, 0);
    en = 0; start = 1; op_i = 3'd0; a_i = 16'h0005; b_i = 16'h0006;
    @(negedge clk);
    chk("en0_8", {done8, busy8, o8}, {2'b00, model(8, 3'd1, 16'h0003, 16'h0004)});
    chk("en0_16", {done16, busy16, o16}, {2'b00, model(16, 3'd1, 16'h0003, 16'h0004)});
    start = 0; en = 1;
    @(negedge clk);
    chk("en0_late", {done8, done16, busy8, busy16}, 0);
    for (int i = 0; i < 60; i++)
      run(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);
    start = 1; op_i = 3'd7; a_i = 16'h00FF; b_i = 16'h00FF;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstmid8", {busy8, done8, o8}, 0);
    chk("rstmid16", {busy16, done16, o16}, 0);
    d = 0;
    repeat (20) begin
      @(negedge clk);
      d += int'(done8) + int'(done16);
    end
    chk("rst_nodone", d, 0);
    run(3'd0, 16'h1234, 16'h0F0F, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
